// File: rtl/tdl_thermo_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tdl_thermo_encoder
// Brief    : Tapped-delay-line receiver. Double-samples the tap vector,
//            detects a rising edge on tap 0, popcounts the thermometer code
//            into a bubble-tolerant fine time, tags it with a free-running
//            coarse counter and emits one word on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module tdl_thermo_encoder #(
    parameter int NTAPS       = 200,
    parameter int FINE_W      = 8,
    parameter int COARSE_W    = 16,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NTAPS-1:0]    taps_in,
    output logic                hit_valid,
    input  logic                hit_ready,
    output logic [FINE_W-1:0]   fine_code,
    output logic [COARSE_W-1:0] coarse_time,
    output logic [7:0]          lost_cnt,
    output logic                busy
);

    localparam int          HALF      = NTAPS / 2;
    localparam logic [3:0]  DEAD_LAST = 4'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        DEAD     = 2'd2
    } state_t;

    // Capture pipeline
    logic [NTAPS-1:0]    taps_q1_q, taps_q1_d;
    logic [NTAPS-1:0]    taps_q2_q, taps_q2_d;
    logic                t0_prev_q, t0_prev_d;
    logic [COARSE_W-1:0] coarse_cnt_q, coarse_cnt_d;

    // Detection FSM
    state_t              state_q, state_d;
    logic [3:0]          dead_cnt_q, dead_cnt_d;
    logic                hit_det;

    // Encoder stage E1
    logic                e1_valid_q, e1_valid_d;
    logic [FINE_W-1:0]   pop_lo_q, pop_lo_d;
    logic [FINE_W-1:0]   pop_hi_q, pop_hi_d;
    logic [COARSE_W-1:0] coarse_s_q, coarse_s_d;

    // Output register
    logic                hit_valid_q, hit_valid_d;
    logic [FINE_W-1:0]   fine_code_q, fine_code_d;
    logic [COARSE_W-1:0] coarse_time_q, coarse_time_d;
    logic [7:0]          lost_cnt_q, lost_cnt_d;
    logic [FINE_W-1:0]   fine_sum;
    logic                handshake;

    // Sampling flops, metastability stage and the free-running coarse counter
    always_comb begin
        taps_q1_d    = taps_in;
        taps_q2_d    = taps_q1_q;
        t0_prev_d    = taps_q2_q[0];
        coarse_cnt_d = coarse_cnt_q + COARSE_W'(1);
    end

    // Edge detector: one hit per rising edge of tap 0, then a dead window,
    // then tap 0 must be seen low again before the next hit can be armed
    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        hit_det    = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                if (!taps_q2_q[0] && enable) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_d = WAIT_LOW;
                end else if (taps_q2_q[0] && !t0_prev_q) begin
                    hit_det    = 1'b1;
                    state_d    = DEAD;
                    dead_cnt_d = '0;
                end
            end
            DEAD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d    = WAIT_LOW;
                    dead_cnt_d = '0;
                end else begin
                    dead_cnt_d = dead_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = WAIT_LOW;
                dead_cnt_d = '0;
            end
        endcase
    end

    // E1: split popcount keeps the adder tree shallow; counting set taps
    // rather than locating the transition makes isolated bubbles harmless
    always_comb begin
        e1_valid_d = hit_det;
        pop_lo_d   = pop_lo_q;
        pop_hi_d   = pop_hi_q;
        coarse_s_d = coarse_s_q;
        if (hit_det) begin
            pop_lo_d = '0;
            pop_hi_d = '0;
            for (int i = 0; i < HALF; i++) begin
                pop_lo_d = pop_lo_d + FINE_W'(taps_q2_q[i]);
            end
            for (int i = HALF; i < NTAPS; i++) begin
                pop_hi_d = pop_hi_d + FINE_W'(taps_q2_q[i]);
            end
            coarse_s_d = coarse_cnt_q;
        end
    end

    // E2 sum feeds the single-entry output register; a result arriving while
    // the held word is stalled is dropped and counted
    always_comb begin
        fine_sum      = pop_lo_q + pop_hi_q;
        handshake     = hit_valid_q & hit_ready;
        hit_valid_d   = hit_valid_q;
        fine_code_d   = fine_code_q;
        coarse_time_d = coarse_time_q;
        lost_cnt_d    = lost_cnt_q;
        if (handshake) begin
            hit_valid_d   = 1'b0;
            fine_code_d   = '0;
            coarse_time_d = '0;
        end
        if (e1_valid_q) begin
            if (hit_valid_q && !hit_ready) begin
                if (lost_cnt_q != 8'hFF) begin
                    lost_cnt_d = lost_cnt_q + 8'd1;
                end
            end else begin
                hit_valid_d   = 1'b1;
                fine_code_d   = fine_sum;
                coarse_time_d = coarse_s_q;
            end
        end
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q1_q     <= '0;
            taps_q2_q     <= '0;
            t0_prev_q     <= 1'b0;
            coarse_cnt_q  <= '0;
            state_q       <= WAIT_LOW;
            dead_cnt_q    <= '0;
            e1_valid_q    <= 1'b0;
            pop_lo_q      <= '0;
            pop_hi_q      <= '0;
            coarse_s_q    <= '0;
            hit_valid_q   <= 1'b0;
            fine_code_q   <= '0;
            coarse_time_q <= '0;
            lost_cnt_q    <= '0;
        end else begin
            taps_q1_q     <= taps_q1_d;
            taps_q2_q     <= taps_q2_d;
            t0_prev_q     <= t0_prev_d;
            coarse_cnt_q  <= coarse_cnt_d;
            state_q       <= state_d;
            dead_cnt_q    <= dead_cnt_d;
            e1_valid_q    <= e1_valid_d;
            pop_lo_q      <= pop_lo_d;
            pop_hi_q      <= pop_hi_d;
            coarse_s_q    <= coarse_s_d;
            hit_valid_q   <= hit_valid_d;
            fine_code_q   <= fine_code_d;
            coarse_time_q <= coarse_time_d;
            lost_cnt_q    <= lost_cnt_d;
        end
    end

    assign hit_valid   = hit_valid_q;
    assign fine_code   = fine_code_q;
    assign coarse_time = coarse_time_q;
    assign lost_cnt    = lost_cnt_q;
    assign busy        = (state_q != ARMED);

endmodule
`default_nettype wire

// File: doc/tdl_thermo_encoder.md
# tdl_thermo_encoder

Receiving end of the CARRY4 tapped delay line in the TDC. The block samples the delay line's tap vector on every clock and detects a new hit on the first tap. It converts the thermometer code into a bubble-tolerant fine-time count and tags the result with a free-running coarse-time counter. Each result goes out as one word on a valid/ready interface toward the timestamp FIFO.

## Interface
Parameters:
- NTAPS, 200, number of delay-line taps (4 per CARRY4).
- FINE_W, 8, fine-code width; must satisfy 2^FINE_W > NTAPS.
- COARSE_W, 16, coarse counter width.
- DEAD_CYCLES, 4, minimum clocks between detected hits, range 1..15.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  system/sampling clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  while 0, no new hits are detected.
- taps_in  in  NTAPS  raw carry outputs from the delay line, asynchronous to clk.
- hit_valid  out  1  result word available.
- hit_ready  in  1  consumer accepts the word.
- fine_code  out  FINE_W  number of set taps in the hit sample.
- coarse_time  out  COARSE_W  coarse counter value at detection.
- lost_cnt  out  8  saturating count of results dropped on backpressure.
- busy  out  1  state is not ARMED.

## Operation
- Capture pipeline:
  - taps_q1 <= taps_in every clock; this is the sampling edge.
  - taps_q2 <= taps_q1 (metastability stage).
  - t0_prev <= taps_q2[0].
- Coarse counter increments every clock and wraps modulo 2^COARSE_W.
- FSM states: WAIT_LOW, ARMED, DEAD.
  - WAIT_LOW -> ARMED when taps_q2[0]==0 and enable==1.
  - ARMED -> DEAD on hit_det = taps_q2[0] & ~t0_prev & enable.
  - ARMED -> WAIT_LOW if enable falls.
  - DEAD counts DEAD_CYCLES clocks, then goes to WAIT_LOW.
  - A level that stays high therefore produces exactly one hit.
- Encoding:
  - On hit_det, latch coarse_time_s = coarse counter.
  - Latch popcounts of taps_q2 lower half [NTAPS/2-1:0] and upper half, separately (stage E1).
  - Next clock, fine = lower + upper (stage E2).
  - The popcount makes isolated bubbles harmless.
  - fine_code range is 1..NTAPS.
  - fine_code == NTAPS means the line was fully traversed: the clock period exceeds the line delay. The value is reported as-is.
- Output register:
  - One entry. Holds fine_code and coarse_time stable while hit_valid & ~hit_ready.
  - The word is cleared on a handshake (valid & ready).
  - If E2 completes while hit_valid & ~hit_ready, the new result is dropped, the held word is unchanged, and lost_cnt += 1, saturating at 255.
  - If E2 completes in the same cycle as a handshake, the new word is loaded and hit_valid stays 1; nothing is dropped.
- Reset values, all outputs:
  - hit_valid=0, fine_code=0, coarse_time=0, lost_cnt=0.
  - busy=1, because state is WAIT_LOW.
  - Internal state: coarse counter 0, taps_q1/q2=0, t0_prev=0, dead counter 0.
- Reset mid-operation: in-flight E1/E2 data and the held output word are discarded. No partial word is presented.

## Timing
- Edge k samples taps_in into taps_q1.
- Edge k+1: taps_q2 valid; hit_det evaluated combinationally after it.
- Edge k+2: E1 registered, coarse_time_s = counter value at edge k+2 minus 1, i.e. the value present during the hit_det cycle.
- Edge k+3: E2 result loads the output register; hit_valid is high in the cycle after edge k+3.
- Throughput: one hit per DEAD_CYCLES+2 clocks minimum (DEAD plus WAIT_LOW plus ARMED re-entry), and only if taps_in[0] falls.
- hit_ready has no combinational path to any output.
- lost_cnt updates one clock after the drop condition.

## Test plan
- Thermometer sweep: taps_in = 0 for 3 clocks, then the low 37 taps set (held two clocks), then all-ones until release -> one word with fine_code=37; coarse_time = counter at detection; no second word while tap0 stays high.
- Bubble: taps_in = ones in [0..59] with bit 30 cleared and bit 62 set -> fine_code=60; then full scale (all 200 set after zero) -> fine_code=200.
- Dead time: pulse tap0 high, low, high at a 2-clock spacing with DEAD_CYCLES=4 -> only the first edge is reported; an edge after 7 clocks is reported.
- Backpressure: hit_ready=0, three hits -> first word held unchanged, lost_cnt=2; raise hit_ready -> one handshake, hit_valid falls next cycle.
- Simultaneous: a handshake in the same cycle as an E2 completion -> new word loaded, hit_valid stays 1, lost_cnt unchanged.
- Reset/enable:
  - Assert rst at the cycle after hit_det -> no word appears, all outputs at reset values.
  - With enable=0, edges on tap0 produce no words and busy=1.
  - Coarse counter wraps from 65535 to 0.
